// File: rtl/oled_init_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : oled_init_seq_pkg                                      |
// | Description : Shared types and constants for the OLED power-up       |
// |               initialisation sequencer (step kinds, pin selects,     |
// |               command bytes, step table entry layout).               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package oled_init_seq_pkg;

  // Kind of action a table step performs
  typedef enum logic [1:0] {
    KIND_PIN   = 2'd0,
    KIND_SPI   = 2'd1,
    KIND_DELAY = 2'd2
  } step_kind_e;

  // Which panel control pin a PIN step writes
  typedef enum logic [1:0] {
    PIN_VDD  = 2'd0,
    PIN_VBAT = 2'd1,
    PIN_RES  = 2'd2,
    PIN_NONE = 2'd3
  } pin_sel_e;

  // Controller command bytes used during bring-up
  localparam logic [7:0] CMD_DISPLAY_OFF    = 8'hAE;
  localparam logic [7:0] CMD_CHARGE_PUMP    = 8'h8D;
  localparam logic [7:0] CMD_CHARGE_PUMP_ON = 8'h14;
  localparam logic [7:0] CMD_PRECHARGE      = 8'hD9;
  localparam logic [7:0] CMD_PRECHARGE_VAL  = 8'hF1;
  localparam logic [7:0] CMD_CONTRAST       = 8'h81;
  localparam logic [7:0] CMD_CONTRAST_VAL   = 8'h0F;
  localparam logic [7:0] CMD_SEG_REMAP      = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_DEC   = 8'hC8;
  localparam logic [7:0] CMD_COM_PINS       = 8'hDA;
  localparam logic [7:0] CMD_COM_PINS_VAL   = 8'h20;
  localparam logic [7:0] CMD_DISPLAY_ON     = 8'hAF;

  // Table length and index of the final step
  localparam int unsigned STEP_COUNT = 19;
  localparam logic [4:0]  LAST_STEP  = 5'(STEP_COUNT - 1);

  // One decoded table entry
  typedef struct packed {
    step_kind_e  kind;
    pin_sel_e    pin;
    logic        value;
    logic [7:0]  cmd;
    logic [11:0] ms;
  } step_t;

  function automatic step_t mk_pin(input pin_sel_e p, input logic v);
    step_t s;
    s.kind  = KIND_PIN;
    s.pin   = p;
    s.value = v;
    s.cmd   = 8'h00;
    s.ms    = 12'd0;
    return s;
  endfunction

  function automatic step_t mk_spi(input logic [7:0] b);
    step_t s;
    s.kind  = KIND_SPI;
    s.pin   = PIN_NONE;
    s.value = 1'b0;
    s.cmd   = b;
    s.ms    = 12'd0;
    return s;
  endfunction

  function automatic step_t mk_dly(input logic [11:0] m);
    step_t s;
    s.kind  = KIND_DELAY;
    s.pin   = PIN_NONE;
    s.value = 1'b0;
    s.cmd   = 8'h00;
    s.ms    = m;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_init_seq_rom.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : oled_init_rom                                          |
// | Description : Combinational step table for the OLED bring-up         |
// |               sequence: step index -> {kind, pin, value, byte, ms}.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module oled_init_rom
  import oled_init_seq_pkg::*;
#(
  parameter int unsigned VDD_WAIT_MS  = 1,
  parameter int unsigned RES_WAIT_MS  = 1,
  parameter int unsigned VBAT_WAIT_MS = 100
) (
  input  logic [4:0] step_i,
  output step_t      entry_o
);

  // Table lookup; indices past the end decode to a no-op pin write
  always_comb begin
    entry_o = mk_pin(PIN_NONE, 1'b0);
    case (step_i)
      5'd0:  entry_o = mk_pin(PIN_VDD, 1'b0);
      5'd1:  entry_o = mk_dly(12'(VDD_WAIT_MS));
      5'd2:  entry_o = mk_spi(CMD_DISPLAY_OFF);
      5'd3:  entry_o = mk_pin(PIN_RES, 1'b0);
      5'd4:  entry_o = mk_dly(12'(RES_WAIT_MS));
      5'd5:  entry_o = mk_pin(PIN_RES, 1'b1);
      5'd6:  entry_o = mk_spi(CMD_CHARGE_PUMP);
      5'd7:  entry_o = mk_spi(CMD_CHARGE_PUMP_ON);
      5'd8:  entry_o = mk_spi(CMD_PRECHARGE);
      5'd9:  entry_o = mk_spi(CMD_PRECHARGE_VAL);
      5'd10: entry_o = mk_pin(PIN_VBAT, 1'b0);
      5'd11: entry_o = mk_dly(12'(VBAT_WAIT_MS));
      5'd12: entry_o = mk_spi(CMD_CONTRAST);
      5'd13: entry_o = mk_spi(CMD_CONTRAST_VAL);
      5'd14: entry_o = mk_spi(CMD_SEG_REMAP);
      5'd15: entry_o = mk_spi(CMD_COM_SCAN_DEC);
      5'd16: entry_o = mk_spi(CMD_COM_PINS);
      5'd17: entry_o = mk_spi(CMD_COM_PINS_VAL);
      5'd18: entry_o = mk_spi(CMD_DISPLAY_ON);
      default: entry_o = mk_pin(PIN_NONE, 1'b0);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/oled_init_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : oled_init_seq                                          |
// | Description : OLED power-up sequencer. Walks the 19-step bring-up    |
// |               table, driving supply/reset pins directly and issuing  |
// |               SPI bytes and ms waits over EN/FIN handshakes.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module oled_init_seq
  import oled_init_seq_pkg::*;
#(
  parameter int unsigned VDD_WAIT_MS  = 1,
  parameter int unsigned RES_WAIT_MS  = 1,
  parameter int unsigned VBAT_WAIT_MS = 100
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  output logic        fin_o,
  output logic        spi_en_o,
  output logic [7:0]  spi_data_o,
  input  logic        spi_fin_i,
  output logic        delay_en_o,
  output logic [11:0] delay_ms_o,
  input  logic        delay_fin_i,
  output logic        dc_o,
  output logic        res_o,
  output logic        vbat_o,
  output logic        vdd_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e      state_q;
  logic [4:0]  step_q;
  logic [4:0]  step_d;
  logic        spi_en_q;
  logic [7:0]  spi_data_q;
  logic        delay_en_q;
  logic [11:0] delay_ms_q;
  logic        res_q;
  logic        vbat_q;
  logic        vdd_q;
  step_t       entry;
  logic        req_fin;

  oled_init_rom #(
    .VDD_WAIT_MS  (VDD_WAIT_MS),
    .RES_WAIT_MS  (RES_WAIT_MS),
    .VBAT_WAIT_MS (VBAT_WAIT_MS)
  ) u_rom (
    .step_i  (step_q),
    .entry_o (entry)
  );

  assign step_d = step_q + 5'd1;

  // Only the FIN belonging to the outstanding request can complete it
  assign req_fin = spi_en_q ? spi_fin_i : delay_fin_i;

  // Sequencer: one table step per ISSUE, one idle cycle per RELEASE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      step_q     <= 5'd0;
      spi_en_q   <= 1'b0;
      spi_data_q <= 8'h00;
      delay_en_q <= 1'b0;
      delay_ms_q <= 12'd0;
      res_q      <= 1'b1;
      vbat_q     <= 1'b1;
      vdd_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_i) begin
            step_q  <= 5'd0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          case (entry.kind)
            KIND_SPI: begin
              spi_data_q <= entry.cmd;
              spi_en_q   <= 1'b1;
              state_q    <= S_WAIT;
            end
            KIND_DELAY: begin
              delay_ms_q <= entry.ms;
              delay_en_q <= 1'b1;
              state_q    <= S_WAIT;
            end
            default: begin
              case (entry.pin)
                PIN_VDD:  vdd_q  <= entry.value;
                PIN_VBAT: vbat_q <= entry.value;
                PIN_RES:  res_q  <= entry.value;
                default:  ;
              endcase
              state_q <= S_RELEASE;
            end
          endcase
        end
        S_WAIT: begin
          if (req_fin) begin
            spi_en_q   <= 1'b0;
            delay_en_q <= 1'b0;
            state_q    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (step_q == LAST_STEP) begin
            state_q <= S_DONE;
          end else begin
            step_q  <= step_d;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (!en_i) begin
            step_q  <= 5'd0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fin_o      = (state_q == S_DONE) && en_i;
  assign spi_en_o   = spi_en_q;
  assign spi_data_o = spi_data_q;
  assign delay_en_o = delay_en_q;
  assign delay_ms_o = delay_ms_q;
  assign dc_o       = 1'b0;
  assign res_o      = res_q;
  assign vbat_o     = vbat_q;
  assign vdd_o      = vdd_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_init_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_oled_init_seq                                       |
// | Description : Self-checking bench for oled_init_seq with behavioural |
// |               SPI/delay responders and a request-order table.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_oled_init_seq;

  localparam int LAT_A = 5;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // DUT A: default parameters, responders with latency 5
  logic        en_a, fin_a, spi_en_a, spi_fin_a, delay_en_a, delay_fin_a;
  logic        dc_a, res_a, vbat_a, vdd_a;
  logic [7:0]  spi_data_a;
  logic [11:0] delay_ms_a;
  // DUT B: zero VBAT wait, responders with latency 0
  logic        en_b, fin_b, spi_en_b, spi_fin_b, delay_en_b, delay_fin_b;
  logic        dc_b, res_b, vbat_b, vdd_b;
  logic [7:0]  spi_data_b;
  logic [11:0] delay_ms_b;

  oled_init_seq dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_a), .fin_o(fin_a),
    .spi_en_o(spi_en_a), .spi_data_o(spi_data_a), .spi_fin_i(spi_fin_a),
    .delay_en_o(delay_en_a), .delay_ms_o(delay_ms_a), .delay_fin_i(delay_fin_a),
    .dc_o(dc_a), .res_o(res_a), .vbat_o(vbat_a), .vdd_o(vdd_a)
  );

  oled_init_seq #(.VBAT_WAIT_MS(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .fin_o(fin_b),
    .spi_en_o(spi_en_b), .spi_data_o(spi_data_b), .spi_fin_i(spi_fin_b),
    .delay_en_o(delay_en_b), .delay_ms_o(delay_ms_b), .delay_fin_i(delay_fin_b),
    .dc_o(dc_b), .res_o(res_b), .vbat_o(vbat_b), .vdd_o(vdd_b)
  );

  // Responder stubs: FIN rises once EN has been high LAT cycles, drops with EN
  int sc_a = 0, dc_cnt_a = 0, sc_b = 0, dc_cnt_b = 0;
  always @(posedge clk) begin
    sc_a     <= spi_en_a   ? sc_a + 1     : 0;
    dc_cnt_a <= delay_en_a ? dc_cnt_a + 1 : 0;
    sc_b     <= spi_en_b   ? sc_b + 1     : 0;
    dc_cnt_b <= delay_en_b ? dc_cnt_b + 1 : 0;
  end
  assign spi_fin_a   = spi_en_a   && (sc_a     >= LAT_A);
  assign delay_fin_a = delay_en_a && (dc_cnt_a >= LAT_A);
  assign spi_fin_b   = spi_en_b   && (sc_b     >= LAT_B);
  assign delay_fin_b = delay_en_b && (dc_cnt_b >= LAT_B);

  typedef struct {
    logic        is_spi;
    logic [11:0] val;
  } vec_t;
  vec_t tbl[15];

  int vecs = 0;
  int fails = 0;

  // Monitor state for DUT A
  logic [12:0] req_log[$];
  logic mon_on = 1'b0;
  int   hs_err = 0;
  logic fin_seen = 1'b0;
  int   vdd_fall_at, res_fall_at, res_rise_at, vbat_fall_at;
  logic p_spi_en = 0, p_dly_en = 0, p_spi_fin = 0, p_dly_fin = 0;
  logic p_vdd = 1, p_vbat = 1, p_res = 1;
  logic [7:0]  p_spi_data = 0;
  logic [11:0] p_dly_ms = 0;
  // Monitor state for DUT B
  int b_spi_cnt = 0, b_dly_cnt = 0, b_err = 0;
  logic pb_spi_en = 0, pb_dly_en = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!vdd_a && p_vdd)   vdd_fall_at  = req_log.size();
      if (!res_a && p_res)   res_fall_at  = req_log.size();
      if (res_a && !p_res)   res_rise_at  = req_log.size();
      if (!vbat_a && p_vbat) vbat_fall_at = req_log.size();
      if (spi_en_a && !p_spi_en) begin
        req_log.push_back({1'b1, 4'h0, spi_data_a});
        if (p_dly_en) hs_err++;
      end
      if (delay_en_a && !p_dly_en) begin
        req_log.push_back({1'b0, delay_ms_a});
        if (p_spi_en) hs_err++;
      end
      if (spi_en_a && delay_en_a) hs_err++;
      if (spi_en_a && p_spi_en && spi_data_a != p_spi_data) hs_err++;
      if (delay_en_a && p_dly_en && delay_ms_a != p_dly_ms) hs_err++;
      if (!spi_en_a && p_spi_en && !p_spi_fin) hs_err++;
      if (!delay_en_a && p_dly_en && !p_dly_fin) hs_err++;
      if (fin_a) fin_seen = 1'b1;
    end
    p_spi_en = spi_en_a;  p_dly_en = delay_en_a;
    p_spi_fin = spi_fin_a; p_dly_fin = delay_fin_a;
    p_spi_data = spi_data_a; p_dly_ms = delay_ms_a;
    p_vdd = vdd_a; p_vbat = vbat_a; p_res = res_a;
    if (spi_en_b && !pb_spi_en) b_spi_cnt++;
    if (delay_en_b && !pb_dly_en) begin
      b_dly_cnt++;
      if (b_dly_cnt == 3 && delay_ms_b != 12'd0) b_err++;
    end
    if (spi_en_b && delay_en_b) b_err++;
    pb_spi_en = spi_en_b; pb_dly_en = delay_en_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    req_log.delete();
    vdd_fall_at = -1; res_fall_at = -1; res_rise_at = -1; vbat_fall_at = -1;
    fin_seen = 1'b0;
    hs_err = 0;
  endtask

  task automatic wait_fin_a(input string name);
    int n;
    n = 0;
    while (!fin_a && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'd0, fin_a}, 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_req_count"}, req_log.size(), 15);
    for (int i = 0; i < 15; i++) begin
      logic [12:0] got;
      got = (i < req_log.size()) ? req_log[i] : 13'h1FFF;
      check($sformatf("%s_req%0d", tag, i), {19'd0, got}, {19'd0, tbl[i].is_spi, tbl[i].val});
    end
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_vdd_at"},  vdd_fall_at,  0);
    check({tag, "_resL_at"}, res_fall_at,  2);
    check({tag, "_resH_at"}, res_rise_at,  3);
    check({tag, "_vbat_at"}, vbat_fall_at, 7);
    check({tag, "_handshake"}, hs_err, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_pins"}, {28'd0, vdd_a, vbat_a, res_a, dc_a}, 32'hE);
    check({tag, "_reqs"}, {10'd0, spi_en_a, delay_en_a, spi_data_a, delay_ms_a}, 32'd0);
    check({tag, "_fin"}, {31'd0, fin_a}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 12'd1};   tbl[1]  = '{1'b1, 12'hAE};
    tbl[2]  = '{1'b0, 12'd1};   tbl[3]  = '{1'b1, 12'h8D};
    tbl[4]  = '{1'b1, 12'h14};  tbl[5]  = '{1'b1, 12'hD9};
    tbl[6]  = '{1'b1, 12'hF1};  tbl[7]  = '{1'b0, 12'd100};
    tbl[8]  = '{1'b1, 12'h81};  tbl[9]  = '{1'b1, 12'h0F};
    tbl[10] = '{1'b1, 12'hA1};  tbl[11] = '{1'b1, 12'hC8};
    tbl[12] = '{1'b1, 12'hDA};  tbl[13] = '{1'b1, 12'h20};
    tbl[14] = '{1'b1, 12'hAF};

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");

    // Scenario 1/2/3: full run with EN held
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;
    en_a = 1'b1;
    @(negedge clk);
    check("vdd_in_issue", {31'd0, vdd_a}, 32'd1);
    @(negedge clk);
    check("vdd_after_issue", {31'd0, vdd_a}, 32'd0);
    wait_fin_a("run1_fin");
    check_log("run1");
    check_pins("run1");
    check("run1_dc", {31'd0, dc_a}, 32'd0);
    @(negedge clk);
    en_a = 1'b0;
    #1 check("fin_drops_with_en", {31'd0, fin_a}, 32'd0);

    // Scenario 4: asynchronous reset during the VBAT wait, then restart
    repeat (3) @(negedge clk);
    clear_mon();
    en_a = 1'b1;
    begin
      int n;
      n = 0;
      while (!(delay_en_a && delay_ms_a == 12'd100) && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("reach_step11", {31'd0, delay_en_a}, 32'd1);
    end
    mon_on = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outs("async_rst");
    repeat (2) @(negedge clk);
    clear_mon();
    mon_on = 1'b1;
    rst_n = 1'b1;
    wait_fin_a("rerun_fin");
    check_log("rerun");
    check_pins("rerun");

    // Scenario 5: EN dropped at step 7; sequence completes without FIN
    @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    en_a = 1'b1;
    begin
      int n;
      n = 0;
      while (req_log.size() < 5 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("reach_step7", req_log.size(), 5);
      en_a = 1'b0;
      n = 0;
      while (req_log.size() < 15 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
    end
    repeat (20) @(posedge clk);
    #1;
    check_log("drop");
    check("drop_no_fin", {31'd0, fin_seen}, 32'd0);
    check("drop_idle_reqs", {30'd0, spi_en_a, delay_en_a}, 32'd0);
    check("drop_handshake", hs_err, 0);
    @(negedge clk);
    clear_mon();
    en_a = 1'b1;
    wait_fin_a("after_drop_fin");
    check_log("after_drop");
    check("after_drop_handshake", hs_err, 0);
    @(negedge clk);
    en_a = 1'b0;

    // Scenario 6: zero-length VBAT wait with zero-latency responders
    b_spi_cnt = 0; b_dly_cnt = 0; b_err = 0;
    en_b = 1'b1;
    begin
      int n;
      n = 0;
      while (!fin_b && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("b_fin", {31'd0, fin_b}, 32'd1);
    check("b_spi_count", b_spi_cnt, 12);
    check("b_delay_count", b_dly_cnt, 3);
    check("b_errors", b_err, 0);
    check("b_pins", {29'd0, vdd_b, vbat_b, res_b}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire
